// File: rtl/sram_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one single-cycle SRAM.
// Data side has priority unless the fetch side has starved STARVE_MAX cycles.
module sram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        RS_NONE,
        RS_INST,
        RS_DATA
    } resp_e;

    resp_e         resp_q, resp_d;
    logic          store_q, store_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_inst, grant_data;
    logic          starved;

    assign starved = (starve_q == SW'(STARVE_MAX));

    // Gated by resetn so nothing is accepted while reset is held.
    always_comb begin
        grant_inst = resetn && inst_req && (!data_req || starved);
        grant_data = resetn && data_req && !grant_inst;
    end

    always_comb begin
        resp_d   = RS_NONE;
        store_d  = 1'b0;
        starve_d = '0;
        if (grant_inst) begin
            resp_d = RS_INST;
        end else if (grant_data) begin
            resp_d  = RS_DATA;
            store_d = data_wr;
        end
        if (inst_req && !grant_inst) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q   <= RS_NONE;
            store_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            resp_q   <= resp_d;
            store_q  <= store_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst || grant_data;
        sram_wen     = (grant_data && data_wr) ? data_wstrb : 4'b0000;
        sram_wdata   = sram_en ? data_wdata : 32'h0;
        sram_addr    = '0;
        if (grant_inst) begin
            sram_addr = inst_addr;
        end else if (grant_data) begin
            sram_addr = data_addr;
        end
    end

    always_comb begin
        inst_data_ok = (resp_q == RS_INST);
        data_data_ok = (resp_q == RS_DATA);
        inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
        data_rdata   = (data_data_ok && !store_q) ? sram_rdata : 32'h0;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: STARVE_MAX, 4, number of consecutive lost cycles after which the instruction side wins.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 inst_req  in  1  instruction fetch request (read only).
REQ-007 inst_addr  in  ADDR_W  fetch address.
REQ-008 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-009 inst_data_ok  out  1  fetch data valid this cycle.
REQ-010 inst_rdata  out  32  fetch data.
REQ-011 data_req  in  1  load/store request.
REQ-012 data_wr  in  1  1 = store, 0 = load.
REQ-013 data_wstrb  in  4  store byte enables.
REQ-014 data_addr  in  ADDR_W  load/store address.
REQ-015 data_wdata  in  32  store data.
REQ-016 data_addr_ok  out  1  load/store accepted this cycle.
REQ-017 data_data_ok  out  1  load data valid, or store complete, this cycle.
REQ-018 data_rdata  out  32  load data.
REQ-019 sram_en  out  1  shared SRAM enable.
REQ-020 sram_wen  out  4  shared SRAM byte write enables.
REQ-021 sram_addr  out  ADDR_W  shared SRAM address.
REQ-022 sram_wdata  out  32  shared SRAM write data.
REQ-023 sram_rdata  in  32  shared SRAM read data, valid one cycle after sram_en.

Function
REQ-024 At most one request SHALL be granted per cycle; the grant is combinational (addr_ok in the same cycle as req).
REQ-025 Only one side requesting: that side SHALL be granted.
REQ-026 Both sides requesting: the data side SHALL win, unless starve_cnt == STARVE_MAX, in which case the instruction side SHALL win.
REQ-027 starve_cnt SHALL increment (saturating at STARVE_MAX) on each cycle inst_req=1 and inst_addr_ok=0.
REQ-028 starve_cnt SHALL clear on inst_addr_ok=1 or inst_req=0.
REQ-029 On grant: sram_en=1; sram_addr = the granted address; sram_wen = data_wstrb if data store, else 4'b0000; sram_wdata = data_wdata.
REQ-030 No grant: sram_en=0, sram_wen=0; sram_addr and sram_wdata are don't-care.
REQ-031 A response register resp_sel {NONE, INST, DATA} SHALL capture the granted side at each clock edge (NONE if no grant).
REQ-032 resp_sel=INST: inst_data_ok=1 and inst_rdata=sram_rdata.
REQ-033 resp_sel=DATA: data_data_ok=1; data_rdata = sram_rdata for a load, 0 for a store.
REQ-034 Each accepted request SHALL receive exactly one data_ok, exactly 1 cycle after its addr_ok.
REQ-035 Back-to-back grants SHALL be allowed every cycle; a response and a new grant may occur in the same cycle.
REQ-036 Requesters hold req and payload stable until addr_ok; the arbiter does not latch unaccepted requests.
REQ-037 data_rdata and inst_rdata SHALL be 0 when the corresponding data_ok=0.

Reset
REQ-038 While resetn=0: all outputs 0, resp_sel=NONE, starve_cnt=0, asynchronously.
REQ-039 A response pending when reset asserts SHALL be dropped; no data_ok after reset release until a new grant.
REQ-040 Requests present during reset SHALL NOT be granted; arbitration resumes on the first rising edge with resetn=1.

Verification
REQ-041 inst_req alone, addr 0x1FC00000, SRAM returns 0x3C010001 -> inst_addr_ok in cycle 0, inst_data_ok with rdata 0x3C010001 in cycle 1.
REQ-042 Both requesting, data store addr 0x100, wstrb 4'b0011 -> data_addr_ok=1, sram_wen=4'b0011, inst_addr_ok=0; data_data_ok next cycle with data_rdata=0.
REQ-043 Both requesting continuously for 6 cycles -> grants D,D,D,D,I,D; starve_cnt reaches 4 then clears.
REQ-044 Alternating grants I,D,I every cycle -> data_ok pulses I,D,I each one cycle later, with no gaps or duplicates.
REQ-045 resetn dropped in the cycle after an inst grant -> inst_data_ok stays 0; all outputs 0 until release; first grant on the first edge after release.
REQ-046 Neither side requesting -> sram_en=0, both data_ok=0, starve_cnt=0.
